// File: rtl/ten_sec_game_ctrl_pkg.sv
// Shared definitions for the ten-second game control stage.
package ten_sec_game_ctrl_pkg;

  // Game state encoding; the timer only latches done while the state is COUNTING (1).
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_RESULT   = 2'd2,
    ST_TIMEOUT  = 2'd3
  } game_state_e;

  // Width of the centisecond measurements.
  localparam int unsigned CS_W = 11;

  // Default timing constants for a 20 kHz clock.
  localparam int unsigned DEF_TICKS_PER_CS    = 200;
  localparam int unsigned DEF_TARGET_CS       = 1000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 400;
  localparam int unsigned DEF_WIN_TOL_CS      = 5;

  // Score bundle presented to the display side.
  typedef struct packed {
    logic [CS_W-1:0] elapsed_cs;
    logic [CS_W-1:0] error_cs;
    logic            win;
  } score_t;

  // Absolute difference of two centisecond values.
  function automatic logic [CS_W-1:0] cs_abs_diff(input logic [CS_W-1:0] a,
                                                  input logic [CS_W-1:0] b);
    return (a >= b) ? CS_W'(a - b) : CS_W'(b - a);
  endfunction

endpackage

// File: rtl/ten_sec_game_ctrl_btn_debounce.sv
// Push-button synchroniser, debouncer and rising-edge pulse generator.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 400
) (
  input  logic clk_20k,
  input  logic reset,
  input  logic btn_raw,
  output logic btn,
  output logic btn_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk_20k or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  // Accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk_20k or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      btn       <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      btn_pulse <= 1'b0;
      if (sync_q[1] != btn) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q     <= '0;
          btn       <= sync_q[1];
          btn_pulse <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/ten_sec_game_ctrl.sv
// Game control stage: debounced button, game FSM, stop-time measurement and scoring.
module ten_sec_game_ctrl
  import ten_sec_game_ctrl_pkg::*;
#(
  parameter int unsigned TICKS_PER_CS    = DEF_TICKS_PER_CS,
  parameter int unsigned TARGET_CS       = DEF_TARGET_CS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned WIN_TOL_CS      = DEF_WIN_TOL_CS
) (
  input  logic            clk_20k,
  input  logic            reset,
  input  logic            btn_raw,
  input  logic            done,
  output logic [1:0]      state,
  output logic            start,
  output logic            btn,
  output logic [CS_W-1:0] elapsed_cs,
  output logic [CS_W-1:0] error_cs,
  output logic            win,
  output logic            result_valid
);

  localparam int unsigned PRESC_W = (TICKS_PER_CS > 2) ? $clog2(TICKS_PER_CS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_CS - 1);
  localparam logic [CS_W-1:0]    TARGET     = CS_W'(TARGET_CS);
  localparam logic [CS_W-1:0]    WIN_TOL    = CS_W'(WIN_TOL_CS);
  localparam logic [CS_W-1:0]    CS_MAX     = '1;

  logic btn_pulse;

  game_state_e        state_q, state_d;
  logic               start_q, start_d;
  logic               valid_q, valid_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  score_t             score_q, score_d;
  logic [CS_W-1:0]    err_c;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_20k  (clk_20k),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn      (btn),
    .btn_pulse(btn_pulse)
  );

  // Distance of the frozen stop time from the target.
  assign err_c = cs_abs_diff(score_q.elapsed_cs, TARGET);

  // State, prescaler and score registers.
  always_ff @(posedge clk_20k or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      presc_q <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      valid_q <= valid_d;
      presc_q <= presc_d;
      score_q <= score_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    valid_d = 1'b0;
    presc_d = presc_q;
    score_d = score_q;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_pulse) begin
          state_d = ST_COUNTING;
          start_d = 1'b1;
          presc_d = '0;
          score_d = '0;
        end
      end
      ST_COUNTING: begin
        if (btn_pulse) begin
          // Player stop wins over a simultaneous timer done; elapsed stays frozen.
          state_d          = ST_RESULT;
          valid_d          = 1'b1;
          score_d.error_cs = err_c;
          score_d.win      = (err_c <= WIN_TOL);
        end else begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (score_q.elapsed_cs != CS_MAX) begin
              score_d.elapsed_cs = score_q.elapsed_cs + CS_W'(1);
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
          if (done) begin
            state_d            = ST_TIMEOUT;
            valid_d            = 1'b1;
            score_d.elapsed_cs = TARGET;
            score_d.error_cs   = '0;
            score_d.win        = 1'b0;
          end else begin
            start_d = 1'b1;
          end
        end
      end
      ST_RESULT: begin
        valid_d = 1'b1;
        if (btn_pulse) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      ST_TIMEOUT: begin
        valid_d = 1'b1;
        if (btn_pulse) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign state        = state_q;
  assign start        = start_q;
  assign result_valid = valid_q;
  assign elapsed_cs   = score_q.elapsed_cs;
  assign error_cs     = score_q.error_cs;
  assign win          = score_q.win;

endmodule
